// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: walks the columns, samples the rows, debounces whole frames
// and reports each accepted key once as a hex code with a one-cycle strobe.
module escaner_teclado #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] tecla,
    output logic       tecla_valida,
    output logic       presionada
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col;
    logic [3:0]       sync1, sync2;
    logic             sample, frame_eval;

    logic [1:0] cur_n, acc_n, tot_n;
    logic [3:0] cur_code, acc_code, tot_code;
    logic [2:0] sum_n;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       cand, cand_n, tecla_n;
    logic             valida_n, pres_n;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col     <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            col     <= col + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign columnas   = ~(4'b0001 << col);
    assign sample     = (div_cnt == DIV_LAST);
    assign frame_eval = sample && (col == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= filas;
            sync2 <= sync1;
        end
    end

    // Key count saturates at 2: anything beyond one key is simply MULTI.
    always_comb begin
        cur_n    = 2'd0;
        cur_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!sync2[r]) begin
                if (cur_n != 2'd2) cur_n = cur_n + 2'd1;
                cur_code = key_map(2'(r), col);
            end
        end
        sum_n    = {1'b0, acc_n} + {1'b0, cur_n};
        tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code = (acc_n != 2'd0) ? acc_code : cur_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_n    <= 2'd0;
            acc_code <= 4'h0;
        end else if (sample) begin
            if (col == 2'd3) begin
                acc_n    <= 2'd0;
                acc_code <= 4'h0;
            end else begin
                acc_n    <= tot_n;
                acc_code <= tot_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cand         <= 4'h0;
            tecla        <= 4'h0;
            tecla_valida <= 1'b0;
            presionada   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cand         <= cand_n;
            tecla        <= tecla_n;
            tecla_valida <= valida_n;
            presionada   <= pres_n;
        end
    end

    // Transitions only on the frame-evaluation cycle; a held key never re-triggers.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        tecla_n  = tecla;
        valida_n = 1'b0;
        pres_n   = presionada;
        if (frame_eval) begin
            case (state)
                ST_IDLE: begin
                    if (tot_n == 2'd1) begin
                        cand_n = tot_code;
                        if (DEBOUNCE == 1) begin
                            tecla_n  = tot_code;
                            valida_n = 1'b1;
                            pres_n   = 1'b1;
                            cnt_n    = '0;
                            state_n  = ST_PRESSED;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (tot_n == 2'd1 && tot_code == cand) begin
                        if (cnt + CNT_W'(1) == DEB_N) begin
                            tecla_n  = cand;
                            valida_n = 1'b1;
                            pres_n   = 1'b1;
                            cnt_n    = '0;
                            state_n  = ST_PRESSED;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (tot_n == 2'd0) begin
                        if (DEBOUNCE == 1) begin
                            pres_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = ST_IDLE;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    if (tot_n == 2'd0) begin
                        if (cnt + CNT_W'(1) == DEB_N) begin
                            pres_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = ST_IDLE;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_PRESSED;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames)
// and a behavioural keypad matrix driving filas from columnas.
module tb_escaner_teclado;

    logic       clk;
    logic       rst_n;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic       presionada;

    logic [15:0] keys;
    int          cyc;
    int          pulses;
    int          checks;
    int          failures;
    logic        prev_valida;

    escaner_teclado #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .filas        (filas),
        .columnas     (columnas),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .presionada   (presionada)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: key bit r*4+c pulls row r low while column c is driven low.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k);
        keys = k;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align_frame();
        for (int i = 0; i < 16 && (cyc % 16) != 0; i++) wait_cycles(1);
    endtask

    // Press at a frame start: accepted at the end of the 2nd frame, released after 2 empty frames.
    task automatic press_and_release(input string tag, input logic [15:0] k, input logic [3:0] code);
        int p0;
        align_frame();
        p0 = pulses;
        applyStimulus(k);
        wait_cycles(31);
        checkOutput({tag, "_no_early_pulse"}, {7'd0, tecla_valida}, 8'd0);
        wait_cycles(1);
        checkOutput({tag, "_valida"}, {7'd0, tecla_valida}, 8'd1);
        checkOutput({tag, "_code"}, {4'd0, tecla}, {4'd0, code});
        checkOutput({tag, "_pres"}, {7'd0, presionada}, 8'd1);
        wait_cycles(16);
        applyStimulus(16'h0000);
        wait_cycles(32);
        checkOutput({tag, "_released"}, {7'd0, presionada}, 8'd0);
        checkOutput({tag, "_one_pulse"}, 8'(pulses - p0), 8'd1);
        wait_cycles(16);
    endtask

    initial prev_valida = 1'b0;
    always @(negedge clk) begin
        if (tecla_valida === 1'b1) begin
            pulses++;
            checkOutput("no_back_to_back", {7'd0, prev_valida}, 8'd0);
        end
        prev_valida = tecla_valida;
    end

    initial begin
        int s;
        int p0;
        checks   = 0;
        failures = 0;
        pulses   = 0;
        keys     = 16'h0000;
        rst_n    = 1'b0;

        // Reset values and column walk
        repeat (3) @(negedge clk);
        checkOutput("rst_columnas", {4'd0, columnas}, 8'h0E);
        checkOutput("rst_tecla", {4'd0, tecla}, 8'h00);
        checkOutput("rst_valida", {7'd0, tecla_valida}, 8'd0);
        checkOutput("rst_pres", {7'd0, presionada}, 8'd0);
        rst_n = 1'b1;
        wait_cycles(4);
        checkOutput("col1", {4'd0, columnas}, 8'h0D);
        wait_cycles(4);
        checkOutput("col2", {4'd0, columnas}, 8'h0B);
        wait_cycles(8);
        checkOutput("col_wrap", {4'd0, columnas}, 8'h0E);

        // Clean press of '6' (row 1, col 2) held for 6 frames
        align_frame();
        s = cyc;
        applyStimulus(16'h0040);
        wait_cycles(31);
        checkOutput("k6_no_early_pulse", {7'd0, tecla_valida}, 8'd0);
        checkOutput("k6_pres_low", {7'd0, presionada}, 8'd0);
        wait_cycles(1);
        checkOutput("k6_valida", {7'd0, tecla_valida}, 8'd1);
        checkOutput("k6_code", {4'd0, tecla}, 8'h06);
        checkOutput("k6_pres", {7'd0, presionada}, 8'd1);
        wait_cycles(1);
        checkOutput("k6_pulse_one_cycle", {7'd0, tecla_valida}, 8'd0);
        wait_cycles(s + 96 - cyc);
        checkOutput("k6_single_pulse", 8'(pulses), 8'd1);

        // Release: presionada holds through the first empty frame, drops after the second
        applyStimulus(16'h0000);
        wait_cycles(31);
        checkOutput("rel_pres_held", {7'd0, presionada}, 8'd1);
        wait_cycles(1);
        checkOutput("rel_pres_drop", {7'd0, presionada}, 8'd0);
        checkOutput("rel_tecla_kept", {4'd0, tecla}, 8'h06);
        press_and_release("k0", 16'h2000, 4'h0);

        // Bounce on '3' (row 0, col 2)
        align_frame();
        p0 = pulses;
        applyStimulus(16'h0004);
        wait_cycles(16);
        checkOutput("bounce_f1_pres", {7'd0, presionada}, 8'd0);
        applyStimulus(16'h0000);
        wait_cycles(16);
        checkOutput("bounce_f2_pres", {7'd0, presionada}, 8'd0);
        applyStimulus(16'h0004);
        wait_cycles(16);
        checkOutput("bounce_f3_pres", {7'd0, presionada}, 8'd0);
        applyStimulus(16'h0000);
        wait_cycles(32);
        checkOutput("bounce_pres", {7'd0, presionada}, 8'd0);
        checkOutput("bounce_no_pulse", 8'(pulses - p0), 8'd0);

        // Multi-key '1'+'5', then the symbol keys
        align_frame();
        p0 = pulses;
        applyStimulus(16'h0021);
        wait_cycles(64);
        checkOutput("multi_no_pulse", 8'(pulses - p0), 8'd0);
        checkOutput("multi_pres", {7'd0, presionada}, 8'd0);
        applyStimulus(16'h0000);
        wait_cycles(16);
        press_and_release("star", 16'h1000, 4'hE);
        press_and_release("hash", 16'h4000, 4'hF);

        // Reset mid-debounce on 'A' (row 0, col 3)
        align_frame();
        p0 = pulses;
        applyStimulus(16'h0008);
        wait_cycles(16);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_columnas", {4'd0, columnas}, 8'h0E);
        checkOutput("midrst_tecla", {4'd0, tecla}, 8'h00);
        checkOutput("midrst_valida", {7'd0, tecla_valida}, 8'd0);
        checkOutput("midrst_pres", {7'd0, presionada}, 8'd0);
        applyStimulus(16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_no_pulse", 8'(pulses - p0), 8'd0);
        press_and_release("kA", 16'h0008, 4'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
